// File: rtl/mem_pkg.sv
// Shared state encoding and sizing helpers for the memory responder.
package mem_pkg;

  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  typedef enum logic [1:0] {
    StClear = CLEAR,
    StLoad  = LOAD,
    StRun   = RUN
  } state_e;

  localparam int unsigned MEM_ADDR_WIDTH = 6;
  localparam int unsigned MEM_DEPTH      = 2 ** MEM_ADDR_WIDTH;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/memory_array.sv
// Single-port synchronous RAM with registered, write-first read data.
module memory_array
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned Depth = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
      dout      <= din;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: clears the array, optionally loads an image, then serves the processor.
// Optional build macro MEMORY_WRITE_PROTECT_EN drops RUN writes below PROTECT_TOP and adds wp_hit.
module memory_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned LOAD_BASE   = 8
`ifdef MEMORY_WRITE_PROTECT_EN
  ,
  parameter int unsigned PROTECT_TOP = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  busy,
  input  logic                  ld_en,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
`ifdef MEMORY_WRITE_PROTECT_EN
  output logic                  wp_hit,
`endif
  output logic [ADDR_WIDTH:0]   ld_count
);

  localparam int unsigned           Depth    = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(Depth - 1);
  localparam logic [ADDR_WIDTH-1:0] LoadBase = ADDR_WIDTH'(LOAD_BASE);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_WIDTH:0]   ld_count_q, ld_count_d;
  logic                  rd_valid_q;

  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_din, arr_dout;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic                  ld_accept;
  logic                  run_we;

  assign load_addr = LoadBase + ld_count_q[ADDR_WIDTH-1:0];
  assign ld_ready  = (state_q == StLoad);
  assign ld_accept = ld_valid & ld_ready;
  assign busy      = (state_q != StRun);
  assign ld_count  = ld_count_q;

`ifdef MEMORY_WRITE_PROTECT_EN
  logic wp_drop;
  logic wp_hit_q;

  // Reads still happen on a dropped write, so out returns the old contents.
  assign wp_drop = (state_q == StRun) && we && (32'(addr) < PROTECT_TOP);
  assign run_we  = we & ~wp_drop;
  assign wp_hit  = wp_hit_q;
`else
  assign run_we  = we;
`endif

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    ld_count_d = ld_count_q;
    arr_we     = 1'b0;
    arr_addr   = addr;
    arr_din    = data;
    unique case (state_q)
      StClear: begin
        arr_we     = 1'b1;
        arr_addr   = clr_cnt_q;
        arr_din    = '0;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        ld_count_d = '0;
        if (clr_cnt_q == LastAddr) begin
          state_d = ld_en ? StLoad : StRun;
        end
      end
      StLoad: begin
        arr_addr = load_addr;
        arr_din  = ld_data;
        if (ld_accept) begin
          arr_we     = 1'b1;
          ld_count_d = ld_count_q + 1'b1;
          // Writing the top address ends the load so the address never wraps.
          if (ld_last || (load_addr == LastAddr)) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        arr_we = run_we;
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StClear;
      clr_cnt_q  <= '0;
      ld_count_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      ld_count_q <= ld_count_d;
      // Only reads launched while serving the processor may reach out.
      rd_valid_q <= (state_q == StRun);
    end
  end

`ifdef MEMORY_WRITE_PROTECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_hit_q <= 1'b0;
    end else begin
      wp_hit_q <= wp_drop;
    end
  end
`endif

  memory_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (arr_addr),
    .din  (arr_din),
    .dout (arr_dout)
  );

  assign out = rd_valid_q ? arr_dout : '0;

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side responder for the processor memory port. The processor drives we/addr/data and samples out one cycle after presenting addr.
- Holds a 2^ADDR_WIDTH x DATA_WIDTH word array.
- After reset it clears the whole array, then optionally accepts a program image over a valid/ready load stream. Only then does it serve processor accesses; busy holds the processor off until that point.

Parameters:
ADDR_WIDTH, 6, word address width; depth = 2^ADDR_WIDTH
DATA_WIDTH, 16, word width
LOAD_BASE, 8, first array address written by the load stream
PROTECT_TOP, 8, addresses below this are read-only in RUN (only with MEMORY_WRITE_PROTECT_EN)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
we  input  1  processor write enable
addr  input  ADDR_WIDTH  processor word address
data  input  DATA_WIDTH  processor write data
out  output  DATA_WIDTH  registered read data
busy  output  1  high while clearing/loading; processor must stall
ld_en  input  1  sampled at end of CLEAR: 1 = enter LOAD, 0 = go to RUN
ld_valid  input  1  load word valid
ld_data  input  DATA_WIDTH  load word
ld_last  input  1  marks final load word
ld_ready  output  1  load word accepted this cycle when ld_valid & ld_ready
ld_count  output  ADDR_WIDTH+1  number of words accepted in the current load

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock. On reset: state = CLEAR, sweep counter = 0, out = 0, busy = 1, ld_ready = 0, ld_count = 0. Array contents are not reset directly.
- Reset asserted mid-operation restarts CLEAR from address 0 and discards any partial load.
- CLEAR:
  - Writes 0 to address = sweep counter each cycle; counter increments.
  - After address 2^ADDR_WIDTH-1 is written (2^ADDR_WIDTH cycles), sample ld_en: 1 goes to LOAD, else RUN.
  - Processor we is ignored. ld_ready = 0.
- LOAD:
  - ld_ready = 1 combinationally.
  - On ld_valid & ld_ready: array[LOAD_BASE + ld_count] <= ld_data and ld_count increments.
  - Exit to RUN the cycle after accepting a word with ld_last = 1, or after writing address 2^ADDR_WIDTH-1; the second case auto-terminates and ignores further words.
  - Address arithmetic is ADDR_WIDTH bits and never wraps to 0.
  - ld_valid low causes no action and no timeout.
- RUN:
  - busy = 0, ld_ready = 0.
  - Read: out <= array[addr] at every rising edge, so data appears the cycle after addr (1-cycle latency).
  - Write: when we = 1, array[addr] <= data. Write-first: out shows the new data the same edge.
  - RUN is left only by reset.
- While busy: out holds 0, processor addr is ignored.
- ld_count holds its final value in RUN.
- Same-edge exit LOAD->RUN: the processor access in that cycle is ignored; busy falls the following cycle.

Optional Feature:
MEMORY_WRITE_PROTECT_EN
- Defined: in RUN, a write with addr < PROTECT_TOP is dropped. out still returns the old array[addr] (read unaffected). Output wp_hit (1 bit, reset 0) pulses for one cycle on each dropped write. CLEAR and LOAD ignore protection.
- Undefined: all RUN writes are performed; no wp_hit port.

Decomposition:
- Package mem_pkg:
  - state encoding localparams: CLEAR = 2'd0, LOAD = 2'd1, RUN = 2'd2
  - array depth constant derived from ADDR_WIDTH
- One sub-module memory_array: single-port synchronous RAM with we/addr/din and registered write-first dout.
- memory_responder muxes the array's address/data/we between the CLEAR counter, the LOAD counter and the processor, and gates out to 0 while busy.

Test Plan:
- Reset release, ld_en = 0 -> busy = 1 for exactly 64 cycles, then 0. Reading any address returns 0x0000.
- ld_en = 1, stream words 0x1111, 0x2222, 0x3333 (last on third) with one idle gap -> ld_count = 3. Reads of addr 8/9/10 return those words, each one cycle after addr; addr 11 reads 0.
- RUN: we = 1, addr = 20, data = 0xBEEF -> out = 0xBEEF the next cycle (write-first). Later read of addr 20 without write -> 0xBEEF.
- Load 56 words with ld_last never asserted -> LOAD ends after address 63; 57th ld_valid sees ld_ready = 0; ld_count = 56.
- Assert rst_n low mid-LOAD after 5 words -> CLEAR restarts; after re-clear with ld_en = 0, addr 8 reads 0x0000.
- With MEMORY_WRITE_PROTECT_EN: write 0x1234 to addr 3 in RUN -> wp_hit pulses once, out shows old value 0x0000. Write to addr 8 -> succeeds, no pulse.
